uart_ctrl: RTL
==============

# uart_ctrl

Parametrised UART controller with internal TX and RX FIFOs. It has runtime-programmable baud divisor, parity mode and stop-bit count, and reports RX errors (framing, parity, overrun). It generalises the fixed-baud 8N1 UART top and sits between an AXI-Stream-style byte producer/consumer and the board UART pins.

## Interface
Parameters:
- WORD_LENGTH, 8, data bits per frame (5..9)
- FIFO_DEPTH, 16, entries per FIFO; power of 2, ≥2
- DIV_WIDTH, 16, width of baud divisor

Ports:
- clk  in  1  single clock
- resetn  in  1  synchronous, active-low reset
- baud_div  in  DIV_WIDTH  clocks per bit; values <4 treated as 4
- parity_mode  in  2  0=none, 1=even, 2=odd, 3=none
- stop2  in  1  1=two stop bits on TX
- tx_data  in  WORD_LENGTH  TX byte
- tx_data_valid  in  1  TX handshake
- tx_data_ready  out  1  high when TX FIFO not full
- UART_TX  out  1  serial out, idle high
- UART_RX  in  1  serial in, asynchronous
- rx_data  out  WORD_LENGTH  head of RX FIFO
- rx_data_valid  out  1  RX FIFO not empty
- rx_data_ready  in  1  RX pop
- tx_level, rx_level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
- tx_busy  out  1  TX FSM not IDLE or TX FIFO not empty
- frame_err, parity_err, overrun_err  out  1 each  sticky error flags
- err_clear  in  1  clears all sticky flags
- rx_state_debug  out  3  RX FSM state encoding

## Operation
- FIFOs: circular buffer, read/write pointers one bit wider than the address. Push on valid&&ready. RX is first-word fall-through: rx_data = head, and a pop occurs on rx_data_valid&&rx_data_ready.
- TX FIFO full: tx_data_ready=0. A pop in the same cycle does not enable a push.
- TX FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE with FIFO non-empty: pop the word, latch baud_div/parity_mode/stop2, then go to START.
  - Each state lasts baud_div cycles. Data is sent LSB first.
  - PARITY is skipped when parity_mode is none. Even parity: the parity bit makes the count of 1s even, including data. Odd parity: the count of 1s is odd.
  - STOP lasts 1 or 2 bit periods.
  - After STOP, go to IDLE. IDLE lasts one cycle before the next pop.
- RX FSM states (rx_state_debug): IDLE=0, START=1, DATA=2, PARITY=3, STOP=4.
  - UART_RX passes through a 2-FF synchroniser. Detection acts on the synchronised value.
  - IDLE: on a high→low transition, latch config, go to START, and load the counter with baud_div/2 (floor).
  - START: at counter expiry, sample the line. If high, it is a false start: go to IDLE with no flag. If low, go to DATA.
  - DATA and PARITY: sample every baud_div cycles.
  - STOP: only one stop bit is checked, regardless of stop2.
- At the stop sample:
  - If stop=0, set frame_err.
  - If the parity bit mismatches, set parity_err.
  - The word is pushed to the RX FIFO even when in error.
  - If the RX FIFO is full and not popping that cycle, drop the word and set overrun_err.
  - Then go to IDLE. Next start detect is possible on the following cycle.
- Sticky flags:
  - err_clear has priority over a same-cycle set.
  - Flags stay set until err_clear or reset.
- Config changes mid-frame do not affect the frame in progress.

## Timing
- Reset (resetn=0 at a clock edge):
  - UART_TX=1, tx_data_ready=0 during reset and 1 the cycle after.
  - rx_data_valid=0, levels=0, tx_busy=0, all err flags=0, rx_state_debug=0.
  - FIFOs are emptied and both FSMs go to IDLE.
  - Reset mid-frame aborts immediately: UART_TX returns high on the reset edge and any partial RX word is discarded.
- TX latency: with TX idle and the FIFO empty, accepting a word at edge E drives UART_TX low after edge E+2.
- Frame length: the frame is (1 + WORD_LENGTH + P + S)·baud_div cycles, where P is 1 with parity and 0 without, and S is the number of stop bits (1 or 2).
- RX latency: the sample point is 2 (synchroniser) + baud_div/2 + k·baud_div cycles after the line falls. rx_data_valid rises 1 cycle after the stop sample.
- Levels: tx_level and rx_level update on the same edge as the push/pop. A simultaneous push and pop leaves the level unchanged.
- Outputs are registered. UART_TX is glitch-free.

## Test plan
- 8N1, baud_div=16: push 0xA5. UART_TX must show 0, then 1,0,1,0,0,1,0,1, then 1, with each bit lasting exactly 16 cycles and the frame lasting 160 cycles. tx_busy falls after STOP.
- Even parity, stop2=1: push 0x03. The parity bit must be 0, followed by 32 cycles of high. With odd parity the same byte gives parity 1.
- Loopback (UART_TX→UART_RX), baud_div=10: push 0x00, 0xFF, 0x5A back-to-back. The RX FIFO must output the same 3 bytes in order, with no error flags set.
- Drive an RX frame for 0x41 with stop bit 0. frame_err must set, 0x41 must be delivered, and err_clear must drop frame_err to 0 the next cycle.
- FIFO_DEPTH=4, rx_data_ready=0: receive 5 bytes. rx_level must be 4, overrun_err=1, and the FIFO must contain bytes 1–4. A 3-cycle low glitch on UART_RX (baud_div=16) causes no push and no flag.
- Assert resetn=0 mid-TX-data-bit. UART_TX must be 1 on the next edge and tx_level must be 0. After release, a new 0x55 must transmit correctly.

Source files
------------

// File: rtl/uart_ctrl.sv
// uart_ctrl: UART controller with TX/RX FIFOs, runtime baud divisor, parity and stop-bit
// configuration, and sticky RX error reporting.
//
// Ports:
//   clk, resetn              single clock, synchronous active-low reset
//   baud_div                 clocks per bit (values below 4 act as 4)
//   parity_mode, stop2       0/3 = no parity, 1 = even, 2 = odd; stop2 selects two TX stop bits
//   tx_data/_valid/_ready    byte producer handshake into the TX FIFO
//   UART_TX, UART_RX         serial pins (TX idles high, RX is asynchronous)
//   rx_data/_valid/_ready    first-word fall-through RX FIFO head and pop handshake
//   tx_level, rx_level       FIFO occupancy
//   tx_busy                  frame in flight or words waiting
//   frame_err, parity_err,
//   overrun_err, err_clear   sticky RX error flags and their clear
//   rx_state_debug           RX FSM state (0 idle .. 4 stop)
module uart_ctrl #(
    parameter int unsigned WORD_LENGTH = 8,
    parameter int unsigned FIFO_DEPTH  = 16,
    parameter int unsigned DIV_WIDTH   = 16
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic [DIV_WIDTH-1:0]         baud_div,
    input  logic [1:0]                   parity_mode,
    input  logic                         stop2,
    input  logic [WORD_LENGTH-1:0]       tx_data,
    input  logic                         tx_data_valid,
    output logic                         tx_data_ready,
    output logic                         UART_TX,
    input  logic                         UART_RX,
    output logic [WORD_LENGTH-1:0]       rx_data,
    output logic                         rx_data_valid,
    input  logic                         rx_data_ready,
    output logic [$clog2(FIFO_DEPTH):0]  tx_level,
    output logic [$clog2(FIFO_DEPTH):0]  rx_level,
    output logic                         tx_busy,
    output logic                         frame_err,
    output logic                         parity_err,
    output logic                         overrun_err,
    input  logic                         err_clear,
    output logic [2:0]                   rx_state_debug
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned BW = $clog2(WORD_LENGTH + 1);

    typedef enum logic [2:0] {
        TxIdle   = 3'd0,
        TxStart  = 3'd1,
        TxData   = 3'd2,
        TxParity = 3'd3,
        TxStop   = 3'd4
    } tx_state_t;

    typedef enum logic [2:0] {
        RxIdle   = 3'd0,
        RxStart  = 3'd1,
        RxData   = 3'd2,
        RxParity = 3'd3,
        RxStop   = 3'd4
    } rx_state_t;

    // Effective divisor with the lower clamp applied.
    logic [DIV_WIDTH-1:0] w_div_eff;
    assign w_div_eff = (baud_div < DIV_WIDTH'(4)) ? DIV_WIDTH'(4) : baud_div;

    // Holds tx_data_ready low while in reset and for the reset edge itself.
    logic r_ready_en;
    always_ff @(posedge clk) begin
        if (!resetn) r_ready_en <= 1'b0;
        else         r_ready_en <= 1'b1;
    end

    // ------------------------------------------------------------------
    // TX FIFO
    // ------------------------------------------------------------------
    logic [WORD_LENGTH-1:0] r_tx_mem [FIFO_DEPTH];
    logic [PW-1:0]          r_tx_wptr, r_tx_rptr;
    logic                   w_tx_empty, w_tx_full, w_tx_push, w_tx_pop;
    logic [WORD_LENGTH-1:0] w_tx_head;

    assign w_tx_empty    = (r_tx_wptr == r_tx_rptr);
    assign w_tx_full     = (r_tx_wptr[AW-1:0] == r_tx_rptr[AW-1:0]) &&
                           (r_tx_wptr[AW] != r_tx_rptr[AW]);
    // Readiness depends on fullness alone; a same-cycle pop never frees a slot early.
    assign tx_data_ready = r_ready_en && !w_tx_full;
    assign w_tx_push     = tx_data_valid && tx_data_ready;
    assign w_tx_head     = r_tx_mem[r_tx_rptr[AW-1:0]];
    assign tx_level      = r_tx_wptr - r_tx_rptr;

    always_ff @(posedge clk) begin
        if (w_tx_push) r_tx_mem[r_tx_wptr[AW-1:0]] <= tx_data;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_tx_wptr <= '0;
            r_tx_rptr <= '0;
        end else begin
            if (w_tx_push) r_tx_wptr <= r_tx_wptr + PW'(1);
            if (w_tx_pop)  r_tx_rptr <= r_tx_rptr + PW'(1);
        end
    end

    // ------------------------------------------------------------------
    // TX FSM
    // ------------------------------------------------------------------
    tx_state_t              r_tx_state, w_tx_state_next;
    logic [DIV_WIDTH-1:0]   r_tx_cnt, w_tx_cnt_next;
    logic [BW-1:0]          r_tx_bit, w_tx_bit_next;
    logic [WORD_LENGTH-1:0] r_tx_shift, w_tx_shift_next;
    logic [DIV_WIDTH-1:0]   r_tx_div, w_tx_div_next;
    logic                   r_tx_par_en, w_tx_par_en_next;
    logic                   r_tx_par_bit, w_tx_par_bit_next;
    logic                   r_tx_stop2, w_tx_stop2_next;
    logic                   r_uart_tx, r_tx_busy;
    logic                   w_tx_line, w_tx_tick;

    assign w_tx_tick = (r_tx_cnt == '0);

    always_comb begin
        w_tx_state_next   = r_tx_state;
        w_tx_cnt_next     = r_tx_cnt;
        w_tx_bit_next     = r_tx_bit;
        w_tx_shift_next   = r_tx_shift;
        w_tx_div_next     = r_tx_div;
        w_tx_par_en_next  = r_tx_par_en;
        w_tx_par_bit_next = r_tx_par_bit;
        w_tx_stop2_next   = r_tx_stop2;
        w_tx_pop          = 1'b0;
        w_tx_line         = 1'b1;
        unique case (r_tx_state)
            TxIdle: begin
                if (!w_tx_empty) begin
                    // Snapshot word and config so mid-frame changes are ignored.
                    w_tx_pop          = 1'b1;
                    w_tx_shift_next   = w_tx_head;
                    w_tx_div_next     = w_div_eff;
                    w_tx_par_en_next  = (parity_mode == 2'd1) || (parity_mode == 2'd2);
                    w_tx_par_bit_next = (^w_tx_head) ^ (parity_mode == 2'd2);
                    w_tx_stop2_next   = stop2;
                    w_tx_cnt_next     = w_div_eff - DIV_WIDTH'(1);
                    w_tx_state_next   = TxStart;
                end
            end
            TxStart: begin
                w_tx_line = 1'b0;
                if (w_tx_tick) begin
                    w_tx_cnt_next   = r_tx_div - DIV_WIDTH'(1);
                    w_tx_bit_next   = '0;
                    w_tx_state_next = TxData;
                end else begin
                    w_tx_cnt_next = r_tx_cnt - DIV_WIDTH'(1);
                end
            end
            TxData: begin
                w_tx_line = r_tx_shift[0];
                if (w_tx_tick) begin
                    w_tx_shift_next = r_tx_shift >> 1;
                    w_tx_cnt_next   = r_tx_div - DIV_WIDTH'(1);
                    if (r_tx_bit == BW'(WORD_LENGTH - 1)) begin
                        w_tx_bit_next   = '0;
                        w_tx_state_next = r_tx_par_en ? TxParity : TxStop;
                    end else begin
                        w_tx_bit_next = r_tx_bit + BW'(1);
                    end
                end else begin
                    w_tx_cnt_next = r_tx_cnt - DIV_WIDTH'(1);
                end
            end
            TxParity: begin
                w_tx_line = r_tx_par_bit;
                if (w_tx_tick) begin
                    w_tx_cnt_next   = r_tx_div - DIV_WIDTH'(1);
                    w_tx_bit_next   = '0;
                    w_tx_state_next = TxStop;
                end else begin
                    w_tx_cnt_next = r_tx_cnt - DIV_WIDTH'(1);
                end
            end
            TxStop: begin
                w_tx_line = 1'b1;
                if (w_tx_tick) begin
                    // r_tx_bit counts completed stop bits here.
                    if (r_tx_stop2 && (r_tx_bit == '0)) begin
                        w_tx_bit_next = BW'(1);
                        w_tx_cnt_next = r_tx_div - DIV_WIDTH'(1);
                    end else begin
                        w_tx_state_next = TxIdle;
                    end
                end else begin
                    w_tx_cnt_next = r_tx_cnt - DIV_WIDTH'(1);
                end
            end
            default: w_tx_state_next = TxIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_tx_state   <= TxIdle;
            r_tx_cnt     <= '0;
            r_tx_bit     <= '0;
            r_tx_shift   <= '0;
            r_tx_div     <= DIV_WIDTH'(4);
            r_tx_par_en  <= 1'b0;
            r_tx_par_bit <= 1'b0;
            r_tx_stop2   <= 1'b0;
            r_uart_tx    <= 1'b1;
            r_tx_busy    <= 1'b0;
        end else begin
            r_tx_state   <= w_tx_state_next;
            r_tx_cnt     <= w_tx_cnt_next;
            r_tx_bit     <= w_tx_bit_next;
            r_tx_shift   <= w_tx_shift_next;
            r_tx_div     <= w_tx_div_next;
            r_tx_par_en  <= w_tx_par_en_next;
            r_tx_par_bit <= w_tx_par_bit_next;
            r_tx_stop2   <= w_tx_stop2_next;
            r_uart_tx    <= w_tx_line;
            r_tx_busy    <= (r_tx_state != TxIdle) || !w_tx_empty;
        end
    end

    assign UART_TX = r_uart_tx;
    assign tx_busy = r_tx_busy;

    // ------------------------------------------------------------------
    // RX synchroniser and FIFO
    // ------------------------------------------------------------------
    logic r_rx_sync1, r_rx_sync2, r_rx_prev;
    logic w_rx_fall;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_rx_sync1 <= 1'b1;
            r_rx_sync2 <= 1'b1;
            r_rx_prev  <= 1'b1;
        end else begin
            r_rx_sync1 <= UART_RX;
            r_rx_sync2 <= r_rx_sync1;
            r_rx_prev  <= r_rx_sync2;
        end
    end

    assign w_rx_fall = r_rx_prev && !r_rx_sync2;

    logic [WORD_LENGTH-1:0] r_rx_mem [FIFO_DEPTH];
    logic [PW-1:0]          r_rx_wptr, r_rx_rptr;
    logic                   w_rx_empty, w_rx_full, w_rx_push, w_rx_pop;
    logic [WORD_LENGTH-1:0] r_rx_shift, w_rx_shift_next;

    assign w_rx_empty    = (r_rx_wptr == r_rx_rptr);
    assign w_rx_full     = (r_rx_wptr[AW-1:0] == r_rx_rptr[AW-1:0]) &&
                           (r_rx_wptr[AW] != r_rx_rptr[AW]);
    assign rx_data_valid = !w_rx_empty;
    assign rx_data       = r_rx_mem[r_rx_rptr[AW-1:0]];
    assign w_rx_pop      = rx_data_valid && rx_data_ready;
    assign rx_level      = r_rx_wptr - r_rx_rptr;

    always_ff @(posedge clk) begin
        if (w_rx_push) r_rx_mem[r_rx_wptr[AW-1:0]] <= r_rx_shift;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_rx_wptr <= '0;
            r_rx_rptr <= '0;
        end else begin
            if (w_rx_push) r_rx_wptr <= r_rx_wptr + PW'(1);
            if (w_rx_pop)  r_rx_rptr <= r_rx_rptr + PW'(1);
        end
    end

    // ------------------------------------------------------------------
    // RX FSM
    // ------------------------------------------------------------------
    rx_state_t            r_rx_state, w_rx_state_next;
    logic [DIV_WIDTH-1:0] r_rx_cnt, w_rx_cnt_next;
    logic [BW-1:0]        r_rx_bit, w_rx_bit_next;
    logic [DIV_WIDTH-1:0] r_rx_div, w_rx_div_next;
    logic                 r_rx_par_en, w_rx_par_en_next;
    logic                 r_rx_par_odd, w_rx_par_odd_next;
    logic                 r_rx_par_bit, w_rx_par_bit_next;
    logic                 w_rx_tick;
    logic                 w_set_frame, w_set_parity, w_set_overrun;

    assign w_rx_tick = (r_rx_cnt == '0);

    always_comb begin
        w_rx_state_next   = r_rx_state;
        w_rx_cnt_next     = r_rx_cnt;
        w_rx_bit_next     = r_rx_bit;
        w_rx_shift_next   = r_rx_shift;
        w_rx_div_next     = r_rx_div;
        w_rx_par_en_next  = r_rx_par_en;
        w_rx_par_odd_next = r_rx_par_odd;
        w_rx_par_bit_next = r_rx_par_bit;
        w_rx_push         = 1'b0;
        w_set_frame       = 1'b0;
        w_set_parity      = 1'b0;
        w_set_overrun     = 1'b0;
        unique case (r_rx_state)
            RxIdle: begin
                if (w_rx_fall) begin
                    w_rx_div_next     = w_div_eff;
                    w_rx_par_en_next  = (parity_mode == 2'd1) || (parity_mode == 2'd2);
                    w_rx_par_odd_next = (parity_mode == 2'd2);
                    // Half a bit puts later samples near each bit centre.
                    w_rx_cnt_next     = w_div_eff >> 1;
                    w_rx_state_next   = RxStart;
                end
            end
            RxStart: begin
                if (w_rx_tick) begin
                    if (r_rx_sync2) begin
                        w_rx_state_next = RxIdle;
                    end else begin
                        w_rx_cnt_next   = r_rx_div - DIV_WIDTH'(1);
                        w_rx_bit_next   = '0;
                        w_rx_state_next = RxData;
                    end
                end else begin
                    w_rx_cnt_next = r_rx_cnt - DIV_WIDTH'(1);
                end
            end
            RxData: begin
                if (w_rx_tick) begin
                    w_rx_shift_next = {r_rx_sync2, r_rx_shift[WORD_LENGTH-1:1]};
                    w_rx_cnt_next   = r_rx_div - DIV_WIDTH'(1);
                    if (r_rx_bit == BW'(WORD_LENGTH - 1)) begin
                        w_rx_state_next = r_rx_par_en ? RxParity : RxStop;
                    end else begin
                        w_rx_bit_next = r_rx_bit + BW'(1);
                    end
                end else begin
                    w_rx_cnt_next = r_rx_cnt - DIV_WIDTH'(1);
                end
            end
            RxParity: begin
                if (w_rx_tick) begin
                    w_rx_par_bit_next = r_rx_sync2;
                    w_rx_cnt_next     = r_rx_div - DIV_WIDTH'(1);
                    w_rx_state_next   = RxStop;
                end else begin
                    w_rx_cnt_next = r_rx_cnt - DIV_WIDTH'(1);
                end
            end
            RxStop: begin
                if (w_rx_tick) begin
                    w_set_frame  = !r_rx_sync2;
                    w_set_parity = r_rx_par_en &&
                                   (r_rx_par_bit != ((^r_rx_shift) ^ r_rx_par_odd));
                    // A same-cycle pop frees the slot the new word lands in.
                    if (w_rx_full && !w_rx_pop) w_set_overrun = 1'b1;
                    else                        w_rx_push     = 1'b1;
                    w_rx_state_next = RxIdle;
                end else begin
                    w_rx_cnt_next = r_rx_cnt - DIV_WIDTH'(1);
                end
            end
            default: w_rx_state_next = RxIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_rx_state   <= RxIdle;
            r_rx_cnt     <= '0;
            r_rx_bit     <= '0;
            r_rx_shift   <= '0;
            r_rx_div     <= DIV_WIDTH'(4);
            r_rx_par_en  <= 1'b0;
            r_rx_par_odd <= 1'b0;
            r_rx_par_bit <= 1'b0;
        end else begin
            r_rx_state   <= w_rx_state_next;
            r_rx_cnt     <= w_rx_cnt_next;
            r_rx_bit     <= w_rx_bit_next;
            r_rx_shift   <= w_rx_shift_next;
            r_rx_div     <= w_rx_div_next;
            r_rx_par_en  <= w_rx_par_en_next;
            r_rx_par_odd <= w_rx_par_odd_next;
            r_rx_par_bit <= w_rx_par_bit_next;
        end
    end

    assign rx_state_debug = r_rx_state;

    // ------------------------------------------------------------------
    // Sticky error flags (clear wins over a same-cycle set)
    // ------------------------------------------------------------------
    logic r_frame_err, r_parity_err, r_overrun_err;

    always_ff @(posedge clk) begin
        if (!resetn || err_clear) begin
            r_frame_err   <= 1'b0;
            r_parity_err  <= 1'b0;
            r_overrun_err <= 1'b0;
        end else begin
            if (w_set_frame)   r_frame_err   <= 1'b1;
            if (w_set_parity)  r_parity_err  <= 1'b1;
            if (w_set_overrun) r_overrun_err <= 1'b1;
        end
    end

    assign frame_err   = r_frame_err;
    assign parity_err  = r_parity_err;
    assign overrun_err = r_overrun_err;

endmodule
